// File: rtl/sram_pkg.sv
// Shared definitions for the Wishbone-to-SRAM primary-port controller.
// Contents: FSM state encoding, SRAM word-address offset within the byte
// address, legal read-latency bounds and the wait-counter width.
package sram_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_ACK       = 2'd3
  } sram_state_e;

  // Byte address bit where the SRAM word address starts (32-bit words).
  localparam int SRAM_WORD_ADDRESS_LSB = 2;

  // Legal macro read latencies, counted from the SRAM capture edge.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  // Width of the read-wait down-counter; holds values up to READ_LATENCY_MAX-1.
  localparam int WAIT_CNT_W = 2;

endpackage

// File: rtl/sram_wishbone_controller.sv
// Wishbone classic slave driving the primary RW port of the SRAM wrapper.
// Turns each Wishbone read/write into a one-cycle SRAM select pulse, waits out
// the macro read latency and returns registered read data with a one-cycle ack.
// Ports: clk/rst (async active-low); wb_* bus slave side; sram_* wrapper
// primary-port side; busy is high whenever the FSM is not idle.
// Latency: write ack 2 cycles after the request, read ack 2+READ_LATENCY.
module sram_wishbone_controller
  import sram_pkg::*;
#(
  parameter int BYTE_COUNT   = 4,
  parameter int ADDRESS_SIZE = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [BYTE_COUNT-1:0]     wb_sel_i,
  input  logic [ADDRESS_SIZE+1:0]   wb_adr_i,
  input  logic [8*BYTE_COUNT-1:0]   wb_data_i,
  output logic                      wb_ack_o,
  output logic [8*BYTE_COUNT-1:0]   wb_data_o,
  output logic                      sram_select,
  output logic                      sram_write_enable,
  output logic [BYTE_COUNT-1:0]     sram_write_mask,
  output logic [ADDRESS_SIZE-1:0]   sram_address,
  output logic [8*BYTE_COUNT-1:0]   sram_data_write,
  input  logic [8*BYTE_COUNT-1:0]   sram_data_read,
  output logic                      busy
);

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("sram_wishbone_controller: READ_LATENCY must be 1 or 2");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(READ_LATENCY - 1);

  sram_state_e               state_q, state_d;
  logic [WAIT_CNT_W-1:0]     cnt_q, cnt_d;
  logic                      select_q, select_d;
  logic                      we_q, we_d;
  logic [BYTE_COUNT-1:0]     mask_q, mask_d;
  logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
  logic [8*BYTE_COUNT-1:0]   wdata_q, wdata_d;
  logic [8*BYTE_COUNT-1:0]   rdata_q, rdata_d;

  // Byte-offset bits of the bus address carry no information for word access.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^wb_adr_i[SRAM_WORD_ADDRESS_LSB-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    // Select/enable/mask are pulses: they only survive the single ACCESS cycle.
    select_d = 1'b0;
    we_d     = 1'b0;
    mask_d   = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d  = ST_ACCESS;
          select_d = 1'b1;
          we_d     = wb_we_i;
          mask_d   = wb_we_i ? wb_sel_i : '0;
          addr_d   = wb_adr_i[ADDRESS_SIZE+1:SRAM_WORD_ADDRESS_LSB];
          wdata_d  = wb_data_i;
        end
      end
      ST_ACCESS: begin
        // The SRAM captures at the edge leaving this state, so an abort here
        // still lets a presented write commit.
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (we_q) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_READ_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_READ_WAIT: begin
        // Abort wins over capture so an abandoned read never disturbs wb_data_o.
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          rdata_d = sram_data_read;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_ACK: begin
        // Strobe deliberately not sampled here: a held stb cannot re-issue.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      select_q <= 1'b0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Ack is qualified by cyc so a master dropping cyc in ACK sees no ack.
  assign wb_ack_o          = (state_q == ST_ACK) && wb_cyc_i;
  assign wb_data_o         = rdata_q;
  assign sram_select       = select_q;
  assign sram_write_enable = we_q;
  assign sram_write_mask   = mask_q;
  assign sram_address      = addr_q;
  assign sram_data_write   = wdata_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: doc/sram_wishbone_controller.md
# sram_wishbone_controller

Wishbone classic slave that acts as the initiator for the primary RW port of the team's SKY130 SRAM wrapper. It turns single Wishbone reads and writes into one-cycle SRAM select pulses and absorbs the macro's read latency. It returns data and `wb_ack_o` to the bus. It sits between the peripheral address decoder and the SRAM wrapper; the wrapper's secondary R port stays with other clients.

## Interface
- `BYTE_COUNT`, 4: bytes per SRAM word; word width is `8*BYTE_COUNT`.
- `ADDRESS_SIZE`, 9: SRAM word-address width; must match the wrapper instance.
- `READ_LATENCY`, 1: cycles from the SRAM capture edge until `sram_data_read` is valid; legal values 1 and 2.

- `clk`  in  1  single clock for the bus and the SRAM.
- `rst`  in  1  reset, asynchronous, active-low.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe; the upstream decoder has already qualified it for this block.
- `wb_we_i`  in  1  1 = write.
- `wb_sel_i`  in  `BYTE_COUNT`  byte lane enables.
- `wb_adr_i`  in  `ADDRESS_SIZE+2`  byte address; bits [1:0] are ignored.
- `wb_data_i`  in  `8*BYTE_COUNT`  write data.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `wb_data_o`  out  `8*BYTE_COUNT`  read data; registered and held until the next read completes.
- `sram_select`  out  1  drives the wrapper's `primarySelect`.
- `sram_write_enable`  out  1  drives `primaryWriteEnable`.
- `sram_write_mask`  out  `BYTE_COUNT`  drives `primaryWriteMask`.
- `sram_address`  out  `ADDRESS_SIZE`  drives `primaryAddress`.
- `sram_data_write`  out  `8*BYTE_COUNT`  drives `primaryDataWrite`.
- `sram_data_read`  in  `8*BYTE_COUNT`  from `primaryDataRead`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: accepts a request when `wb_cyc_i & wb_stb_i`. Goes to ACCESS and registers all `sram_*` outputs on the same edge:
    - `sram_address = wb_adr_i[ADDRESS_SIZE+1:2]`
    - `sram_write_enable = wb_we_i`
    - `sram_write_mask = wb_we_i ? wb_sel_i : 0`
    - `sram_data_write = wb_data_i`
  - ACCESS: `sram_select` = 1 for exactly this one cycle. A write goes to ACK. A read goes to READ_WAIT, with the wait counter loaded to `READ_LATENCY-1`.
  - READ_WAIT: counts down. When the counter is 0, captures `sram_data_read` into `wb_data_o` and goes to ACK.
  - ACK: `wb_ack_o` = 1 for one cycle, then IDLE. The strobe is not sampled in ACK, so a held `stb` never double-issues.
- Write with `wb_sel_i` = 0: the SRAM is still selected with a zero mask, and the write is acknowledged normally.
- Abort: `wb_cyc_i` low in ACCESS, READ_WAIT or ACK sends the FSM to IDLE next cycle with no ack.
  - An SRAM write already presented in ACCESS still commits.
  - An aborted read leaves `wb_data_o` unchanged.
- `sram_select`, `sram_write_enable` and `sram_write_mask` are 0 outside ACCESS. `sram_address` and `sram_data_write` hold their last values.

## Timing
- Request sampled at edge E0:
  - SRAM captures at E1.
  - Write: ack is high in the cycle after E1. Bus latency is 2 cycles.
  - Read: `wb_data_o` and ack are both updated at edge `E(1+READ_LATENCY)`. Bus latency is `2+READ_LATENCY` cycles.
- Back-to-back throughput: one transaction per 3 cycles for writes, and per `3+READ_LATENCY` cycles for reads. The next request is sampled at the first IDLE edge.
- Reset (asynchronous, any state): state = IDLE. `wb_ack_o`, `wb_data_o`, all `sram_*` outputs, `busy` and the counter all = 0. Behaviour on exit from reset is the same as a fresh start.

## Structure
- Shared package `sram_pkg`:
  - FSM state encoding (IDLE, ACCESS, READ_WAIT, ACK).
  - `SRAM_WORD_ADDRESS_LSB` = 2.
  - Legal `READ_LATENCY` bounds.
- Single flat module; no sub-module.
- The top level pairs this block with the RW_R SRAM wrapper.

## Test plan
- Write `0xDEADBEEF` to byte address `0x010` with sel `4'hF`, then read it back -> `sram_address` = 4, `sram_select` pulses 1 cycle, write ack 2 cycles after the request, read returns `0xDEADBEEF` with ack 3 cycles after the request.
- Write `0x000000AA` with sel `4'b0001` over `0x11223344` -> read returns `0x112233AA`.
- `READ_LATENCY` = 2 with a behavioural SRAM model -> read ack exactly 4 cycles after the request, and data matches.
- Master holds `stb` high through ack, with a second request back-to-back -> exactly two SRAM selects and two acks.
- `wb_cyc_i` dropped in READ_WAIT -> no ack, `wb_data_o` unchanged, FSM back in IDLE next cycle.
- `rst` asserted asynchronously mid-read -> all outputs 0 immediately. A write after release to `0x7FC` (word 511) succeeds and reads back correctly.
